// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: default table geometry,
// the entry record, the flush FSM encoding and small helpers.
// Optional feature macro used by the top: BP_GSHARE_EN.

`ifndef BP_IDX_W
`define BP_IDX_W(n) $clog2(n)
`endif

package branch_predictor_pkg;

    // Default table geometry
    localparam int BP_ENTRIES = 64;
    localparam int BP_CNT_W   = 2;
    localparam int BP_TAG_W   = 8;

    // One table entry at the default geometry
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        logic [BP_CNT_W-1:0] cnt;
    } bp_entry_t;

    // Flush controller states
    typedef enum logic {
        FLUSH_IDLE  = 1'b0,
        FLUSH_SWEEP = 1'b1
    } flush_state_t;

    // 32-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down direction counter step: given the current count and
// the resolved direction, produce the next count, clamped to 0..2^CNT_W-1.

module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Step towards taken on inc, towards not-taken otherwise, holding at the rails
    always_comb begin
        cnt_out = cnt_in;
        if (inc) begin
            if (cnt_in != CNT_MAX) begin
                cnt_out = cnt_in + CNT_W'(1);
            end
        end else begin
            if (cnt_in != '0) begin
                cnt_out = cnt_in - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch history table plus branch target buffer. ID looks up the fetch PC
// combinationally; EX writes resolved outcomes back one per cycle. A flush
// sweeps the table one entry per cycle while busy is high; updates arriving
// during the sweep are dropped and not counted.
// Optional feature: define BP_GSHARE_EN to XOR a global history register
// into the table index (gshare). Without it the index is PC bits only.
//
// Update port handshake: update_valid is a one-cycle strobe with no ready;
// the update is taken at the next rising edge exactly when busy is low.

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int CNT_W   = BP_CNT_W,
    parameter int TAG_W   = BP_TAG_W,
    parameter int IDX_W   = `BP_IDX_W(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             predict_hit,
    output logic             predict_taken,
    output logic [31:0]      predict_target,
    output logic [IDX_W-1:0] predict_ghr,
    input  logic             update_valid,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_mispredict,
    input  logic [IDX_W-1:0] update_ghr,
    input  logic             flush_all,
    output logic             busy,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispredict_cnt
);

    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ENTRIES - 1);

    // Table storage, one array per entry field
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    // Flush controller
    flush_state_t     state_q, state_d;
    logic [IDX_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic             sweep_clr;

    // Statistics
    logic [31:0]      branch_cnt_q;
    logic [31:0]      mispredict_cnt_q;

    // Index / tag / update decode
    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_accept;
    logic             upd_hit;
    logic [CNT_W-1:0] upd_cnt_next;

    // Only the index and tag fields of update_pc reach the table
    logic             unused_bits;
    assign unused_bits = ^{update_pc, update_ghr};

    assign look_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_tag  = update_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    // Shift every accepted outcome into the global history; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_accept) begin
            ghr_q <= {ghr_q[IDX_W-2:0], update_taken};
        end
    end

    assign look_idx    = lookup_pc[IDX_W+1:2] ^ ghr_q;
    assign upd_idx     = update_pc[IDX_W+1:2] ^ update_ghr;
    assign predict_ghr = ghr_q;
`else
    assign look_idx    = lookup_pc[IDX_W+1:2];
    assign upd_idx     = update_pc[IDX_W+1:2];
    assign predict_ghr = '0;
`endif

    // Lookup reads registered state only, so a same-cycle update is not visible
    always_comb begin
        predict_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && !busy;
        predict_taken  = predict_hit && cnt_q[look_idx][CNT_W-1];
        predict_target = predict_taken ? target_q[look_idx] : lookup_pc + 32'd4;
    end

    assign upd_accept = update_valid && !busy;
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    bp_sat_counter #(
        .CNT_W (CNT_W)
    ) u_upd_cnt (
        .cnt_in  (cnt_q[upd_idx]),
        .inc     (update_taken),
        .cnt_out (upd_cnt_next)
    );

    // Flush FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FLUSH_IDLE;
            sweep_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
        end
    end

    // Flush FSM next state: clear one entry per SWEEP cycle, leave after the last
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        sweep_clr   = 1'b0;
        case (state_q)
            FLUSH_IDLE: begin
                if (flush_all) begin
                    state_d     = FLUSH_SWEEP;
                    sweep_ptr_d = '0;
                end
            end
            FLUSH_SWEEP: begin
                sweep_clr = 1'b1;
                if (sweep_ptr_q == LAST_IDX) begin
                    state_d = FLUSH_IDLE;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = FLUSH_IDLE;
            end
        endcase
    end

    assign busy = (state_q == FLUSH_SWEEP);

    // Table write port: sweep clear, or train on hit, or allocate on taken miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
        end else if (sweep_clr) begin
            valid_q[sweep_ptr_q] <= 1'b0;
            cnt_q[sweep_ptr_q]   <= CNT_WEAK_NT;
        end else if (upd_accept) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= upd_cnt_next;
                if (update_taken) begin
                    target_q[upd_idx] <= update_target;
                end
            end else if (update_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= update_target;
                cnt_q[upd_idx]    <= CNT_WEAK_T;
            end
        end
    end

    // Statistics counters; a flush leaves them alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (upd_accept) begin
            branch_cnt_q <= sat_inc32(branch_cnt_q);
            if (update_mispredict) begin
                mispredict_cnt_q <= sat_inc32(mispredict_cnt_q);
            end
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a behavioural table model checked against the
// DUT every falling edge, plus directed scenarios with literal expectations.

module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      lookup_pc = 32'h40;
    logic             predict_hit;
    logic             predict_taken;
    logic [31:0]      predict_target;
    logic [IDX_W-1:0] predict_ghr;
    logic             update_valid = 1'b0;
    logic [31:0]      update_pc = '0;
    logic             update_taken = 1'b0;
    logic [31:0]      update_target = '0;
    logic             update_mispredict = 1'b0;
    logic [IDX_W-1:0] update_ghr = '0;
    logic             flush_all = 1'b0;
    logic             busy;
    logic [31:0]      branch_cnt;
    logic [31:0]      mispredict_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    bit cmp_en       = 1'b0;

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_pc         (lookup_pc),
        .predict_hit       (predict_hit),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .predict_ghr       (predict_ghr),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .update_ghr        (update_ghr),
        .flush_all         (flush_all),
        .busy              (busy),
        .branch_cnt        (branch_cnt),
        .mispredict_cnt    (mispredict_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int          m_busy_left;
    longint      m_bcnt, m_mcnt;
    int          m_ghr;

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_cnt[i]    = (1 << (CNT_W - 1)) - 1;
        end
        m_busy_left = 0;
        m_bcnt = 0;
        m_mcnt = 0;
        m_ghr  = 0;
    endtask

    task automatic m_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                            input bit mis, input int ghr_in);
        int idx;
        int unsigned tg;
        idx = pc_idx(pc);
`ifdef BP_GSHARE_EN
        idx = idx ^ ghr_in;
`endif
        tg = pc_tag(pc);
        if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
        if (mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            if (taken) begin
                if (m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
                m_target[idx] = tgt;
            end else if (m_cnt[idx] > 0) begin
                m_cnt[idx]--;
            end
        end else if (taken) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = tg;
            m_target[idx] = tgt;
            m_cnt[idx]    = 1 << (CNT_W - 1);
        end
`ifdef BP_GSHARE_EN
        m_ghr = ((m_ghr << 1) | int'(taken)) % ENTRIES;
`endif
    endtask

    // Model advances on the same edges as the DUT. A flush is modelled as
    // "busy for ENTRIES cycles, table empty afterwards": lookups are masked
    // and updates dropped while busy, so the sweep order is not observable.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end else begin
                if (update_valid)
                    m_update(update_pc, update_taken, update_target, update_mispredict, int'(update_ghr));
                if (flush_all) begin
                    m_busy_left = ENTRIES;
                    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
                end
            end
        end
    end

    // Compare process: every falling edge out of reset
    initial begin
        forever begin
            int idx;
            bit e_hit, e_taken;
            logic [31:0] e_tgt;
            @(negedge clk);
            if (!rst && cmp_en) begin
                idx = pc_idx(lookup_pc);
`ifdef BP_GSHARE_EN
                idx = idx ^ m_ghr;
`endif
                e_hit   = (m_busy_left == 0) && m_valid[idx] && (m_tag[idx] == pc_tag(lookup_pc));
                e_taken = e_hit && (m_cnt[idx] >= (1 << (CNT_W - 1)));
                e_tgt   = e_taken ? m_target[idx] : lookup_pc + 32'd4;
                check("cmp_hit",    predict_hit,    e_hit);
                check("cmp_taken",  predict_taken,  e_taken);
                check("cmp_target", predict_target, e_tgt);
                check("cmp_busy",   busy,           m_busy_left > 0);
                check("cmp_ghr",    predict_ghr,    m_ghr);
                check("cmp_bcnt",   branch_cnt,     m_bcnt[31:0]);
                check("cmp_mcnt",   mispredict_cnt, m_mcnt[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                             input bit mis, input logic [IDX_W-1:0] ghr);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_target     = tgt;
        update_mispredict = mis;
        update_ghr        = ghr;
        step();
        update_valid      = 1'b0;
    endtask

    task automatic expect_lookup(input string name, input logic [31:0] pc, input bit hit,
                                 input bit taken, input logic [31:0] tgt);
        lookup_pc = pc;
        @(negedge clk);
        check({name, "_hit"},    predict_hit,    hit);
        check({name, "_taken"},  predict_taken,  taken);
        check({name, "_target"}, predict_target, tgt);
        step();
    endtask

    // Directed update vectors: pc, taken, target
    logic [31:0] vec_pc  [6] = '{32'h0000_0000, 32'h0000_0104, 32'h0000_0104, 32'h0001_2344, 32'h0000_0104, 32'h0000_0008};
    bit          vec_tk  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] vec_tgt [6] = '{32'h0000_0800, 32'h0000_0900, 32'h0, 32'h0000_0A00, 32'h0000_0B00, 32'h0};

    // ---------------- stimulus ----------------
    initial begin
        int busy_cycles;
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_hit",    predict_hit,    1'b0);
        check("rst_taken",  predict_taken,  1'b0);
        check("rst_target", predict_target, 32'h44);
        check("rst_bcnt",   branch_cnt,     32'd0);
        check("rst_busy",   busy,           1'b0);
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        step();

`ifdef BP_GSHARE_EN
        // Entry 19 allocated via pc 0x4C with ghr 0, then history becomes 0b11
        do_update(32'h4C, 1'b1, 32'h500, 1'b0, 6'd0);
        do_update(32'h300, 1'b1, 32'h600, 1'b0, 6'd1);
        lookup_pc = 32'h40;
        @(negedge clk);
        check("gs_ghr",    predict_ghr,    6'd3);
        check("gs_hit",    predict_hit,    1'b1);
        check("gs_target", predict_target, 32'h500);
        step();
`else
        // Allocate 0x40; the lookup in the same cycle still sees the old entry
        lookup_pc         = 32'h40;
        update_valid      = 1'b1;
        update_pc         = 32'h40;
        update_taken      = 1'b1;
        update_target     = 32'h100;
        update_mispredict = 1'b1;
        @(negedge clk);
        check("same_cycle_hit", predict_hit, 1'b0);
        step();
        update_valid = 1'b0;
        expect_lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

        // Counter 2 -> 1 -> 0 -> 0
        do_update(32'h40, 1'b0, 32'h0, 1'b1, '0);
        expect_lookup("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
        do_update(32'h40, 1'b0, 32'h0, 1'b0, '0);
        do_update(32'h40, 1'b0, 32'h0, 1'b0, '0);
        // Counter 0 -> 1 -> 2 -> 3 -> 3
        do_update(32'h40, 1'b1, 32'h100, 1'b0, '0);
        do_update(32'h40, 1'b1, 32'h100, 1'b0, '0);
        do_update(32'h40, 1'b1, 32'h100, 1'b1, '0);
        do_update(32'h40, 1'b1, 32'h104, 1'b0, '0);
        expect_lookup("sat", 32'h40, 1'b1, 1'b1, 32'h104);
        check("sat_bcnt", branch_cnt,     32'd8);
        check("sat_mcnt", mispredict_cnt, 32'd3);
        // Saturated at 3: one not-taken leaves it predicting taken
        do_update(32'h40, 1'b0, 32'h0, 1'b0, '0);
        expect_lookup("sat_hold", 32'h40, 1'b1, 1'b1, 32'h104);

        // Aliasing on index 16 with a different tag
        expect_lookup("alias_miss", 32'h1040, 1'b0, 1'b0, 32'h1044);
        do_update(32'h1040, 1'b0, 32'h0, 1'b0, '0);
        expect_lookup("alias_nt", 32'h40, 1'b1, 1'b1, 32'h104);
        do_update(32'h1040, 1'b1, 32'h2000, 1'b0, '0);
        expect_lookup("alias_evict", 32'h40, 1'b0, 1'b0, 32'h44);
        expect_lookup("alias_new", 32'h1040, 1'b1, 1'b1, 32'h2000);

        // Fall-through wraps at 32 bits
        expect_lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Assorted vectors checked by the model
        for (int i = 0; i < 6; i++) begin
            do_update(vec_pc[i], vec_tk[i], vec_tgt[i], i[0], '0);
            lookup_pc = vec_pc[i];
            step();
        end
        expect_lookup("vec_104", 32'h104, 1'b1, 1'b1, 32'hB00);

        // Flush: busy for exactly ENTRIES cycles, mid-sweep update and re-flush ignored
        do_update(32'h40, 1'b1, 32'h100, 1'b0, '0);
        lookup_pc = 32'h40;
        flush_all = 1'b1;
        step();
        flush_all   = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            else break;
            step();
            update_valid      = (busy_cycles == 20);
            update_pc         = 32'h40;
            update_taken      = 1'b1;
            update_target     = 32'h900;
            update_mispredict = 1'b1;
            flush_all         = (busy_cycles == 30);
        end
        update_valid = 1'b0;
        flush_all    = 1'b0;
        step();
        check("flush_busy_cycles", busy_cycles,    32'd64);
        check("flush_bcnt",        branch_cnt,     32'd18);
        check("flush_mcnt",        mispredict_cnt, 32'd6);
        expect_lookup("flush_miss", 32'h40, 1'b0, 1'b0, 32'h44);

        // Reset in the middle of a sweep aborts it at once
        do_update(32'h40, 1'b1, 32'h100, 1'b0, '0);
        flush_all = 1'b1;
        step();
        flush_all = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("rst_sweep_busy", busy,       1'b0);
        check("rst_sweep_bcnt", branch_cnt, 32'd0);
        step();
        rst = 1'b0;
        step();
        expect_lookup("rst_sweep_miss", 32'h40, 1'b0, 1'b0, 32'h44);
`endif

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch history table plus branch target buffer, the successor to the fixed predict-bit scheme in the 5-stage core.
- The ID stage looks up the fetch PC in the same cycle and receives a taken/not-taken direction, a target address and a hit flag.
- The EX stage writes the resolved branch outcome back through the update port.
- The block also keeps branch and mispredict statistics, and supports a multi-cycle table flush.

Parameters:
- ENTRIES, 64, number of table entries; must be a power of 2, at least 4. IDX_W = log2(ENTRIES).
- CNT_W, 2, width of the saturating direction counter, 1..4.
- TAG_W, 8, number of PC tag bits stored per entry.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- lookup_pc  in  32  PC of the instruction in ID
- predict_hit  out  1  valid entry with matching tag
- predict_taken  out  1  predicted direction
- predict_target  out  32  predicted next PC
- predict_ghr  out  IDX_W  history snapshot to carry down the pipeline
- update_valid  in  1  EX resolved a branch this cycle
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  actual direction
- update_target  in  32  actual taken target
- update_mispredict  in  1  prediction was wrong (statistics only)
- update_ghr  in  IDX_W  predict_ghr value carried with the branch
- flush_all  in  1  one-cycle pulse starting a table clear
- busy  out  1  flush sweep in progress
- branch_cnt  out  32  accepted updates
- mispredict_cnt  out  32  accepted updates with update_mispredict=1

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2] (optionally XOR ghr, see Optional Feature).
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, target[31:0], cnt[CNT_W-1:0].
- Lookup is combinational from registered state:
  - predict_hit = valid & tag match & ~busy.
  - predict_taken = predict_hit & cnt MSB.
  - predict_target = entry target when predict_taken, else lookup_pc+4 (32-bit wrap).
- Update is accepted when update_valid & ~busy. It takes effect at the next clk rising edge.
- Update on a tag hit:
  - cnt increments on taken, decrements on not-taken, saturating at 0 and 2^CNT_W-1.
  - target is overwritten on taken only.
- Update on a miss:
  - Taken: allocate or replace the entry. valid=1, new tag, target=update_target, cnt=2^(CNT_W-1) (weakly taken).
  - Not-taken: no table change.
- Same-cycle lookup and update on the same index: the lookup sees the pre-update entry. There is no bypass.
- Statistics:
  - Each accepted update increments branch_cnt.
  - mispredict_cnt increments when update_mispredict=1.
  - Both saturate at 0xFFFFFFFF.
  - Updates dropped while busy are not counted.
- Flush FSM:
  - States: IDLE, SWEEP.
  - IDLE→SWEEP on flush_all. The sweep pointer is set to 0 and busy=1 from the next cycle.
  - In SWEEP, one entry per cycle: valid=0, cnt=2^(CNT_W-1)-1.
  - SWEEP→IDLE after entry ENTRIES-1 is cleared, so busy stays high exactly ENTRIES cycles.
  - flush_all during SWEEP is ignored.
  - Statistics are not cleared by a flush.
- Reset (asynchronous), applied to all entries:
  - valid=0, cnt=2^(CNT_W-1)-1, tag=0, target=0.
  - FSM=IDLE, busy=0, counters=0, ghr=0.
  - Resulting outputs: predict_hit=0, predict_taken=0, predict_target=lookup_pc+4.
  - Reset during SWEEP aborts it immediately.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - The block holds a global history register ghr[IDX_W-1:0]. On each accepted update, ghr <= {ghr[IDX_W-2:0], update_taken}.
  - Lookup index = pc idx XOR ghr, and predict_ghr = ghr.
  - Update index = update_pc idx XOR update_ghr.
  - The flush does not clear ghr; reset does.
- Undefined:
  - No ghr register. predict_ghr is tied to 0 and update_ghr is ignored.
  - Index is pc bits only.

Decomposition:
- Shared package (Const.svh): BP_ENTRIES, BP_CNT_W, BP_TAG_W defaults.
- Shared package also holds a typedef bp_entry_t {valid, tag, target, cnt} and the IDX_W derivation macro.
- One sub-module: bp_sat_counter, a parametrised CNT_W saturating inc/dec function block, instantiated per update path.

Test Plan (ENTRIES=64, CNT_W=2, TAG_W=8, macro off unless stated):
- After reset, lookup_pc=0x40 → hit=0, taken=0, target=0x44, branch_cnt=0.
- Update pc=0x40 taken target=0x100, then lookup 0x40 next cycle → hit=1, taken=1, target=0x100. A same-cycle lookup during that update → hit=0.
- Direction saturation on pc=0x40:
  - Three not-taken updates → cnt 2→1→0→0, taken=0 after the first.
  - Then four taken updates → cnt reaches 3 and stays 3, taken=1.
  - branch_cnt=8 overall.
- Aliasing: with 0x40 allocated, lookup 0x1040 → hit=0.
  - Not-taken update of 0x1040 → 0x40 still hits.
  - Taken update of 0x1040 → 0x40 misses.
- Flush: pulse flush_all → busy=1 for exactly 64 cycles, and an update issued mid-sweep is dropped and uncounted. Afterwards 0x40 misses.
  - Repeat with rst asserted at sweep cycle 10 → busy=0 immediately.
- BP_GSHARE_EN defined: after taken updates set ghr=0b000011, lookup 0x40 (idx 16) reads entry 19. predict_ghr=3.
